// File: rtl/afifo_pkg.sv
// Shared definitions for the afifo read-side drain engine: state encoding,
// default widths common with afifo, and the buffer headroom rule.
package afifo_pkg;

    localparam int AFIFO_DWIDTH = 8;
    localparam int AFIFO_CNTW   = 16;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rd_state_t;

    // True while buffered plus in-flight words leave room for one more read.
    function automatic logic has_room(input logic [1:0] occ, input logic infl);
        return (({1'b0, occ} + {2'b00, infl}) < 3'd2);
    endfunction

endpackage

// File: rtl/afifo_reader_if.sv
// FIFO read port plus downstream valid/ready stream of the afifo reader.
interface afifo_reader_if
    import afifo_pkg::*;
#(
    parameter int DWIDTH = AFIFO_DWIDTH
);

    logic              empty;
    logic [DWIDTH-1:0] out;
    logic              ren;
    logic [DWIDTH-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        input  empty,
        input  out,
        output ren,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        output empty,
        output out,
        input  ren,
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/afifo_skid2.sv
// Two-entry FIFO-ordered skid buffer; entry 0 is always the head.
module afifo_skid2
    import afifo_pkg::*;
#(
    parameter int DWIDTH = AFIFO_DWIDTH
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [DWIDTH-1:0] din,
    input  logic              pop,
    output logic [DWIDTH-1:0] head,
    output logic [1:0]        occ
);

    logic [DWIDTH-1:0] ent0_r;
    logic [DWIDTH-1:0] ent1_r;
    logic [1:0]        occ_r;

    // Storage and occupancy update; clear beats any push or pop in the same cycle.
    always_ff @(posedge rclk) begin
        if (rst) begin
            ent0_r <= {DWIDTH{1'b0}};
            ent1_r <= {DWIDTH{1'b0}};
            occ_r  <= 2'd0;
        end else if (clr) begin
            occ_r <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    case (occ_r)
                        2'd0: begin
                            ent0_r <= din;
                            occ_r  <= 2'd1;
                        end
                        2'd1: begin
                            ent1_r <= din;
                            occ_r  <= 2'd2;
                        end
                        default: occ_r <= occ_r;
                    endcase
                end
                2'b01: begin
                    if (occ_r != 2'd0) begin
                        ent0_r <= ent1_r;
                        occ_r  <= occ_r - 2'd1;
                    end else begin
                        occ_r <= occ_r;
                    end
                end
                2'b11: begin
                    // Occupancy is unchanged; only the ordering of entries moves.
                    if (occ_r == 2'd2) begin
                        ent0_r <= ent1_r;
                        ent1_r <= din;
                    end else begin
                        ent0_r <= din;
                    end
                end
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign head = ent0_r;
    assign occ  = occ_r;

endmodule

// File: rtl/afifo_reader.sv
// Read-side drain engine for afifo: throttled read enable, skid buffering,
// valid/ready delivery, flush mode and a delivered-word counter.
module afifo_reader
    import afifo_pkg::*;
#(
    parameter int DWIDTH = AFIFO_DWIDTH,
    parameter int CNTW   = AFIFO_CNTW
) (
    input  logic            rclk,
    input  logic            rst,
    afifo_reader_if.master  bus,
    input  logic            flush,
    output logic            flush_done,
    output logic [CNTW-1:0] rd_count
);

    rd_state_t         state_r;
    logic              infl_r;
    logic              flush_done_r;
    logic [CNTW-1:0]   rd_count_r;

    logic [1:0]        occ_s;
    logic [DWIDTH-1:0] head_s;
    logic              ren_s;
    logic              push_s;
    logic              pop_s;
    logic              clr_s;
    logic              m_valid_s;

    // Read enable, capture, pop and clear decisions for the current state.
    always_comb begin
        ren_s     = 1'b0;
        push_s    = 1'b0;
        clr_s     = 1'b0;
        m_valid_s = (state_r == RUN) && (occ_s != 2'd0);
        pop_s     = m_valid_s && bus.m_ready;
        if (rst) begin
            ren_s = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    ren_s  = !bus.empty && has_room(occ_s, infl_r);
                    push_s = infl_r;
                    clr_s  = flush;
                end
                FLUSH: begin
                    // Drain unthrottled; anything captured is thrown away.
                    ren_s = !bus.empty;
                    clr_s = 1'b1;
                end
                default: begin
                    ren_s = 1'b0;
                end
            endcase
        end
    end

    // Run/flush sequencing, in-flight tracking, completion pulse and counter.
    always_ff @(posedge rclk) begin
        if (rst) begin
            state_r      <= RUN;
            infl_r       <= 1'b0;
            flush_done_r <= 1'b0;
            rd_count_r   <= {CNTW{1'b0}};
        end else begin
            infl_r       <= ren_s;
            flush_done_r <= 1'b0;
            if (pop_s) begin
                rd_count_r <= rd_count_r + {{(CNTW-1){1'b0}}, 1'b1};
            end
            case (state_r)
                RUN: begin
                    if (flush) begin
                        state_r <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (bus.empty && !infl_r) begin
                        state_r      <= RUN;
                        flush_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= RUN;
                end
            endcase
        end
    end

    afifo_skid2 #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .rclk (rclk),
        .rst  (rst),
        .clr  (clr_s),
        .push (push_s),
        .din  (bus.out),
        .pop  (pop_s),
        .head (head_s),
        .occ  (occ_s)
    );

    assign bus.ren     = ren_s;
    assign bus.m_valid = m_valid_s;
    assign bus.m_data  = head_s;
    assign flush_done  = flush_done_r;
    assign rd_count    = rd_count_r;

endmodule

// File: tb/tb_afifo_reader.sv
// Directed bench for afifo_reader with a behavioural afifo read-port model.
module tb_afifo_reader;

    logic        rclk;
    logic        rst;
    logic        flush;
    logic        flush_done;
    logic [15:0] rd_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] got_q[$];

    afifo_reader_if #(.DWIDTH(8)) bus ();

    afifo_reader #(
        .DWIDTH (8),
        .CNTW   (16)
    ) dut (
        .rclk       (rclk),
        .rst        (rst),
        .bus        (bus),
        .flush      (flush),
        .flush_done (flush_done),
        .rd_count   (rd_count)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // FIFO model: registered read data, empty flag refreshed mid-cycle.
    always @(posedge rclk) begin
        if (bus.ren === 1'b1 && fifo_q.size() != 0) begin
            bus.out <= fifo_q.pop_front();
        end
    end

    always @(negedge rclk) begin
        bus.empty <= (fifo_q.size() == 0);
    end

    // Underflow guard watched on every active edge.
    always @(posedge rclk) begin
        if (rst === 1'b0) begin
            checks++;
            if (bus.ren === 1'b1 && bus.empty === 1'b1) begin
                failures++;
                $display("FAIL ren_while_empty: ren=%0b empty=%0b at %0t", bus.ren, bus.empty, $time);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge rclk);
        #1;
    endtask

    task automatic do_reset;
        rst         = 1'b1;
        flush       = 1'b0;
        bus.m_ready = 1'b0;
        fifo_q.delete();
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic drain(input int n, input int budget);
        got_q.delete();
        for (int i = 0; i < budget; i++) begin
            if (got_q.size() == n) break;
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) got_q.push_back(bus.m_data);
            tick;
        end
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (bus.ren !== 1'b0) begin failures++; $display("FAIL rst_ren: got %0b expected 0", bus.ren); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid: got %0b expected 0", bus.m_valid); end
        checks++; if (bus.m_data !== 8'd0) begin failures++; $display("FAIL rst_m_data: got %0d expected 0", bus.m_data); end
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL rst_flush_done: got %0b expected 0", flush_done); end
        checks++; if (rd_count !== 16'd0) begin failures++; $display("FAIL rst_rd_count: got %0d expected 0", rd_count); end
    endtask

    task automatic test_single;
        do_reset;
        bus.m_ready = 1'b1;
        fifo_q.push_back(8'd12);
        tick;
        checks++; if (bus.ren !== 1'b1) begin failures++; $display("FAIL single_ren_high: got %0b expected 1", bus.ren); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %0b expected 0", bus.m_valid); end
        tick;
        checks++; if (bus.ren !== 1'b0) begin failures++; $display("FAIL single_ren_once: got %0b expected 0", bus.ren); end
        tick;
        checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %0b expected 1", bus.m_valid); end
        checks++; if (bus.m_data !== 8'd12) begin failures++; $display("FAIL single_data: got %0d expected 12", bus.m_data); end
        checks++; if (rd_count !== 16'd0) begin failures++; $display("FAIL single_count_before: got %0d expected 0", rd_count); end
        tick;
        checks++; if (rd_count !== 16'd1) begin failures++; $display("FAIL single_count_after: got %0d expected 1", rd_count); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop: got %0b expected 0", bus.m_valid); end
        bus.m_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int ren_cnt;
        do_reset;
        ren_cnt = 0;
        for (int i = 1; i <= 5; i++) fifo_q.push_back(8'(i));
        for (int i = 0; i < 8; i++) begin
            tick;
            if (bus.ren === 1'b1) ren_cnt++;
        end
        checks++; if (ren_cnt != 2) begin failures++; $display("FAIL bp_ren_pulses: got %0d expected 2", ren_cnt); end
        checks++; if (dut.occ_s !== 2'd2) begin failures++; $display("FAIL bp_occ: got %0d expected 2", dut.occ_s); end
        checks++; if (bus.m_data !== 8'd1) begin failures++; $display("FAIL bp_head: got %0d expected 1", bus.m_data); end
        tick;
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'd1) begin failures++; $display("FAIL bp_hold: got valid=%0b data=%0d expected valid=1 data=1", bus.m_valid, bus.m_data); end
        bus.m_ready = 1'b1;
        drain(5, 40);
        checks++; if (got_q.size() != 5) begin failures++; $display("FAIL bp_word_count: got %0d expected 5", got_q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== 8'(i + 1)) begin
                failures++;
                $display("FAIL bp_order[%0d]: got %0d expected %0d", i, (got_q.size() > i) ? got_q[i] : 8'hxx, i + 1);
            end
        end
        checks++; if (rd_count !== 16'd5) begin failures++; $display("FAIL bp_rd_count: got %0d expected 5", rd_count); end
        bus.m_ready = 1'b0;
    endtask

    task automatic test_underflow;
        do_reset;
        for (int i = 0; i < 20; i++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            tick;
            checks++; if (bus.ren !== 1'b0) begin failures++; $display("FAIL uf_ren[%0d]: got %0b expected 0", i, bus.ren); end
            checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL uf_valid[%0d]: got %0b expected 0", i, bus.m_valid); end
        end
        bus.m_ready = 1'b0;
    endtask

    task automatic test_flush;
        int done_cnt;
        int first_done;
        int valid_seen;
        do_reset;
        fifo_q.push_back(8'd12);
        fifo_q.push_back(8'd13);
        fifo_q.push_back(8'd2);
        fifo_q.push_back(8'd7);
        for (int i = 0; i < 4; i++) tick;
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'd12) begin failures++; $display("FAIL fl_pre: got valid=%0b data=%0d expected valid=1 data=12", bus.m_valid, bus.m_data); end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL fl_valid_drop: got %0b expected 0", bus.m_valid); end
        checks++; if (bus.ren !== 1'b1) begin failures++; $display("FAIL fl_ren_drain: got %0b expected 1", bus.ren); end
        done_cnt = 0; first_done = -1; valid_seen = 0;
        for (int i = 1; i <= 14; i++) begin
            tick;
            if (bus.m_valid === 1'b1) valid_seen++;
            if (flush_done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL fl_done_count: got %0d expected 1", done_cnt); end
        checks++; if (first_done != 4) begin failures++; $display("FAIL fl_done_time: got %0d expected 4", first_done); end
        checks++; if (valid_seen != 0) begin failures++; $display("FAIL fl_valid_during: got %0d expected 0", valid_seen); end
        checks++; if (fifo_q.size() != 0) begin failures++; $display("FAIL fl_fifo_drained: got %0d expected 0", fifo_q.size()); end
        checks++; if (rd_count !== 16'd0) begin failures++; $display("FAIL fl_rd_count: got %0d expected 0", rd_count); end
        fifo_q.push_back(8'd13);
        bus.m_ready = 1'b1;
        drain(1, 12);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'd13) begin failures++; $display("FAIL fl_next_word: got n=%0d expected 13", got_q.size()); end
        checks++; if (rd_count !== 16'd1) begin failures++; $display("FAIL fl_count_after: got %0d expected 1", rd_count); end
        bus.m_ready = 1'b0;
    endtask

    task automatic test_simul;
        int done_cnt;
        int hs_cnt;
        do_reset;
        for (int i = 1; i <= 4; i++) fifo_q.push_back(8'(i));
        for (int i = 0; i < 3; i++) tick;
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'd1) begin failures++; $display("FAIL sim_pre: got valid=%0b data=%0d expected valid=1 data=1", bus.m_valid, bus.m_data); end
        bus.m_ready = 1'b1;
        flush       = 1'b1;
        tick;
        flush = 1'b0;
        checks++; if (rd_count !== 16'd1) begin failures++; $display("FAIL sim_count: got %0d expected 1", rd_count); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL sim_valid: got %0b expected 0", bus.m_valid); end
        done_cnt = 0; hs_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.m_valid === 1'b1) hs_cnt++;
            tick;
            if (flush_done === 1'b1) done_cnt++;
        end
        checks++; if (hs_cnt != 0) begin failures++; $display("FAIL sim_stale_words: got %0d expected 0", hs_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL sim_done: got %0d expected 1", done_cnt); end
        fifo_q.push_back(8'd9);
        drain(1, 12);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'd9) begin failures++; $display("FAIL sim_next_word: got n=%0d expected 9", got_q.size()); end
        checks++; if (rd_count !== 16'd2) begin failures++; $display("FAIL sim_count_after: got %0d expected 2", rd_count); end
        bus.m_ready = 1'b0;
    endtask

    task automatic test_reset_midflush;
        int done_cnt;
        do_reset;
        for (int i = 1; i <= 4; i++) fifo_q.push_back(8'(i));
        for (int i = 0; i < 4; i++) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL rmf_in_flush: got %0b expected 0", bus.m_valid); end
        rst = 1'b1;
        tick;
        checks++; if (bus.ren !== 1'b0) begin failures++; $display("FAIL rmf_ren: got %0b expected 0", bus.ren); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL rmf_valid: got %0b expected 0", bus.m_valid); end
        checks++; if (bus.m_data !== 8'd0) begin failures++; $display("FAIL rmf_data: got %0d expected 0", bus.m_data); end
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL rmf_done: got %0b expected 0", flush_done); end
        checks++; if (rd_count !== 16'd0) begin failures++; $display("FAIL rmf_count: got %0d expected 0", rd_count); end
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (flush_done === 1'b1) done_cnt++;
        end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL rmf_no_pulse: got %0d expected 0", done_cnt); end
    endtask

    task automatic test_back_to_back;
        do_reset;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(20 + i));
        drain(8, 60);
        checks++; if (got_q.size() != 8) begin failures++; $display("FAIL b2b_count: got %0d expected 8", got_q.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== 8'(20 + i)) begin
                failures++;
                $display("FAIL b2b_order[%0d]: got %0d expected %0d", i, (got_q.size() > i) ? got_q[i] : 8'hxx, 20 + i);
            end
        end
        checks++; if (rd_count !== 16'd8) begin failures++; $display("FAIL b2b_rd_count: got %0d expected 8", rd_count); end
        bus.m_ready = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        bus.empty   = 1'b1;
        bus.out     = 8'd0;
        bus.m_ready = 1'b0;
        test_reset;
        test_single;
        test_backpressure;
        test_underflow;
        test_flush;
        test_simul;
        test_reset_midflush;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
